// File: rtl/gravity_sensor_ctrl.sv
// SPI-style master for a 3-wire accelerometer: X frame then Y frame per sample pair,
// each frame shifts a 4-bit command out and a 12-bit two's-complement sample in.
module gravity_sensor_ctrl #(
  parameter int         CLK_DIV       = 4,
  parameter int         CS_GAP        = 8,
  parameter int         SAMPLE_PERIOD = 50000,
  parameter logic [3:0] CMD_X         = 4'h1,
  parameter logic [3:0] CMD_Y         = 4'h2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        en,
  input  logic        data,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  output logic [11:0] xvalue,
  output logic [11:0] yvalue,
  output logic        sample_valid,
  output logic        busy
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_DONE, S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          hi_q, hi_d;
  logic          axis_q, axis_d;
  logic [PW-1:0] period_q, period_d;
  logic [11:0]   shift_q, shift_d;
  logic [11:0]   stage_q, stage_d;
  logic [11:0]   xvalue_q, xvalue_d;
  logic [11:0]   yvalue_q, yvalue_d;
  logic          valid_q, valid_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic [3:0]    cmd_sel;
  logic [1:0]    cmd_idx;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      hi_q     <= 1'b0;
      axis_q   <= 1'b0;
      period_q <= '0;
      shift_q  <= '0;
      stage_q  <= '0;
      xvalue_q <= '0;
      yvalue_q <= '0;
      valid_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      hi_q     <= hi_d;
      axis_q   <= axis_d;
      period_q <= period_d;
      shift_q  <= shift_d;
      stage_q  <= stage_d;
      xvalue_q <= xvalue_d;
      yvalue_q <= yvalue_d;
      valid_q  <= valid_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    hi_d     = hi_q;
    axis_d   = axis_q;
    // Period counter saturates so a pair longer than the period restarts straight from DONE
    period_d = (period_q == PER_LAST) ? period_q : period_q + PW'(1);
    shift_d  = shift_q;
    stage_d  = stage_q;
    xvalue_d = xvalue_q;
    yvalue_d = yvalue_q;
    valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        period_d = '0;
        if (en) begin
          state_d = S_SETUP;
          axis_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          hi_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        // Capture on the first cycle of each high half; the four command bits carry no data
        if (hi_q && (cnt_q == '0) && (bit_q >= 4'd4)) shift_d = {shift_q[10:0], data};
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!hi_q) begin
            hi_d = 1'b1;
          end else begin
            hi_d = 1'b0;
            if (bit_q == 4'd15) state_d = S_HOLD;
            else                bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!axis_q) begin
            state_d = S_GAP;
            stage_d = shift_q;
          end else begin
            state_d  = S_DONE;
            xvalue_d = stage_q;
            yvalue_d = shift_q;
            valid_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SETUP;
          axis_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE, S_WAIT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (period_q == PER_LAST) begin
          state_d  = S_SETUP;
          axis_d   = 1'b0;
          cnt_d    = '0;
          period_d = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin outputs are decoded from the next state so they line up with state_q
    cmd_sel = axis_d ? CMD_Y : CMD_X;
    cmd_idx = 2'd3 - bit_d[1:0];
    cs_n_d  = !((state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD));
    sclk_d  = !((state_d == S_SHIFT) && !hi_d);
    mosi_d  = ((state_d == S_SHIFT) && (bit_d < 4'd4)) ? cmd_sel[cmd_idx] : 1'b0;
    busy_d  = !((state_d == S_IDLE) || (state_d == S_WAIT));
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign xvalue       = xvalue_q;
  assign yvalue       = yvalue_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_gravity_sensor_ctrl.sv
// Bench for gravity_sensor_ctrl: two instances (long and short sample period) driven by a
// command-decoding sensor model, checked every cycle against a pair-offset timing model.
module tb_gravity_sensor_ctrl;

  localparam int CD        = 2;
  localparam int GAP       = 4;
  localparam int FRAME     = 34 * CD;
  localparam int PAIR_LEN  = 2 * FRAME + GAP + 1;
  localparam int DONE_OFF  = PAIR_LEN - 1;
  localparam int SP_A      = 200;
  localparam int SP_B      = 10;
  localparam int M_IDLE    = 0;
  localparam int M_PAIR    = 1;
  localparam int M_WAIT    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        en_r;
  logic [1:0]        data_r = '0;
  logic [1:0]        cs_n_w, sclk_w, mosi_w, valid_w, busy_w;
  logic [1:0][11:0]  xv_w, yv_w;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      gravity_sensor_ctrl #(
        .CLK_DIV      (CD),
        .CS_GAP       (GAP),
        .SAMPLE_PERIOD((gi == 0) ? SP_A : SP_B),
        .CMD_X        (4'h1),
        .CMD_Y        (4'h2)
      ) u_dut (
        .clk1        (clk),
        .rst         (rst),
        .en          (en_r[gi]),
        .data        (data_r[gi]),
        .cs_n        (cs_n_w[gi]),
        .sclk        (sclk_w[gi]),
        .mosi        (mosi_w[gi]),
        .xvalue      (xv_w[gi]),
        .yvalue      (yv_w[gi]),
        .sample_valid(valid_w[gi]),
        .busy        (busy_w[gi])
      );
    end
  endgenerate

  // Sensor: decodes the command from mosi on rises 1-4, drives the sample on falls 5-16
  logic [11:0] sx [2];
  logic [11:0] sy [2];
  int          s_rises [2];
  int          s_falls [2];
  logic [3:0]  s_cmd [2];
  logic        s_tail [2];
  int          s_last_rises [2];
  int          s_prev_rises [2];
  logic [3:0]  s_last_cmd [2];
  logic [3:0]  s_prev_cmd [2];
  logic        s_last_tail [2];
  logic        s_prev_tail [2];
  logic        s_pcs [2] = '{1'b1, 1'b1};
  logic        s_psclk [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [11:0] v;
      if (cs_n_w[i]) begin
        if (!s_pcs[i]) begin
          s_prev_rises[i] = s_last_rises[i];
          s_last_rises[i] = s_rises[i];
          s_prev_cmd[i]   = s_last_cmd[i];
          s_last_cmd[i]   = s_cmd[i];
          s_prev_tail[i]  = s_last_tail[i];
          s_last_tail[i]  = s_tail[i];
        end
        s_rises[i] = 0;
        s_falls[i] = 0;
        s_cmd[i]   = 4'h0;
        s_tail[i]  = 1'b0;
        data_r[i]  = 1'b0;
      end else begin
        if (s_psclk[i] && !sclk_w[i]) begin
          s_falls[i]++;
          v = (s_cmd[i] == 4'h1) ? sx[i] : (s_cmd[i] == 4'h2) ? sy[i] : 12'h000;
          data_r[i] = (s_falls[i] >= 5 && s_falls[i] <= 16) ? v[16 - s_falls[i]] : 1'b0;
        end
        if (!s_psclk[i] && sclk_w[i]) begin
          s_rises[i]++;
          if (s_rises[i] <= 4) s_cmd[i] = {s_cmd[i][2:0], mosi_w[i]};
          else                 s_tail[i] = s_tail[i] | mosi_w[i];
        end
      end
      s_pcs[i]   = cs_n_w[i];
      s_psclk[i] = sclk_w[i];
    end
  end

  // Reference model: a pair is a fixed 141-cycle waveform indexed by its offset
  int          m_st [2]  = '{M_IDLE, M_IDLE};
  int          m_off [2] = '{0, 0};
  int          m_per [2] = '{0, 0};
  logic [11:0] ex [2]    = '{12'h0, 12'h0};
  logic [11:0] ey [2]    = '{12'h0, 12'h0};

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   vcnt [2]    = '{0, 0};
  int   last_v [2]  = '{0, 0};
  int   prev_v [2]  = '{0, 0};
  logic cur_cs [2]  = '{1'b1, 1'b1};
  logic prev_cs [2] = '{1'b1, 1'b1};

  function automatic logic [4:0] exp_ctl(input int st, input int off);
    logic cs, sc, mo, va, bu;
    logic [3:0] cmd;
    int p, q, b;
    cs = 1'b1; sc = 1'b1; mo = 1'b0; va = 1'b0; bu = 1'b0;
    cmd = 4'h1; p = -1; q = 0; b = 0;
    if (st == M_PAIR) begin
      bu = 1'b1;
      va = (off == DONE_OFF);
      if (off < FRAME) begin
        p = off; cmd = 4'h1;
      end else if (off >= FRAME + GAP && off < 2 * FRAME + GAP) begin
        p = off - FRAME - GAP; cmd = 4'h2;
      end
      if (p >= 0) begin
        cs = 1'b0;
        if (p >= CD && p < 33 * CD) begin
          q  = p - CD;
          b  = q / (2 * CD);
          sc = (q % (2 * CD)) >= CD;
          if (b < 4) mo = cmd[3 - b];
        end
      end
    end
    return {cs, sc, mo, va, bu};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    int sp;
    logic [4:0] e, a;
    for (int i = 0; i < 2; i++) begin
      sp = (i == 0) ? SP_A : SP_B;
      if (rst) begin
        m_st[i] = M_IDLE; ex[i] = 12'h0; ey[i] = 12'h0;
      end else if (m_st[i] == M_IDLE) begin
        if (en_r[i]) begin m_st[i] = M_PAIR; m_off[i] = 0; m_per[i] = 0; end
      end else if (m_st[i] == M_PAIR && m_off[i] < DONE_OFF) begin
        m_off[i]++; m_per[i]++;
        if (m_off[i] == DONE_OFF) begin ex[i] = sx[i]; ey[i] = sy[i]; end
      end else if (!en_r[i]) begin
        m_st[i] = M_IDLE;
      end else if (m_per[i] >= sp - 1) begin
        m_st[i] = M_PAIR; m_off[i] = 0; m_per[i] = 0;
      end else begin
        m_st[i] = M_WAIT; m_per[i]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      e = exp_ctl(m_st[i], m_off[i]);
      a = {cs_n_w[i], sclk_w[i], mosi_w[i], valid_w[i], busy_w[i]};
      n_tests++;
      if (a !== e || xv_w[i] !== ex[i] || yv_w[i] !== ey[i]) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL cycle %0d inst %0d: cs/sclk/mosi/valid/busy got %b required %b, x got %h required %h, y got %h required %h",
                   cyc, i, a, e, xv_w[i], ex[i], yv_w[i], ey[i]);
      end
      prev_cs[i] = cur_cs[i];
      cur_cs[i]  = cs_n_w[i];
      if (valid_w[i]) begin
        prev_v[i] = last_v[i];
        last_v[i] = cyc;
        vcnt[i]++;
        $display("[TB] cycle %0d inst %0d sample x=%h y=%h", cyc, i, xv_w[i], yv_w[i]);
      end
    end
  endtask

  task automatic wait_valid(input int i, input int target, input int limit, input string nm);
    int k = 0;
    while (vcnt[i] < target && k < limit) begin
      tick();
      k++;
    end
    chk(nm, int'(vcnt[i] >= target), 1);
  endtask

  task automatic wait_off(input int i, input int off, input int limit, input string nm);
    int k = 0;
    while (!(m_st[i] == M_PAIR && m_off[i] == off) && k < limit) begin
      tick();
      k++;
    end
    chk(nm, int'(m_st[i] == M_PAIR && m_off[i] == off), 1);
  endtask

  initial begin
    int t_start, vbase, np, low_after;
    rst = 1'b1;
    en_r = 2'b00;
    sx[0] = 12'hA5C; sy[0] = 12'h3F1;
    sx[1] = 12'h321; sy[1] = 12'hCDE;
    repeat (3) tick();
    chk("reset cs_n", cs_n_w[0], 1);
    chk("reset sclk", sclk_w[0], 1);
    chk("reset mosi", mosi_w[0], 0);
    chk("reset xvalue", xv_w[0], 0);
    chk("reset valid", valid_w[0], 0);
    chk("reset busy", busy_w[0], 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single pair: values, latency, command bits, sclk rise count per window
    en_r[0] = 1'b1;
    t_start = cyc;
    wait_valid(0, 1, 400, "t1 pair completes");
    chk("t1 pair latency", last_v[0] - t_start, PAIR_LEN);
    chk("t1 xvalue", xv_w[0], 12'hA5C);
    chk("t1 yvalue", yv_w[0], 12'h3F1);
    tick();
    chk("t1 X window rises", s_prev_rises[0], 16);
    chk("t1 Y window rises", s_last_rises[0], 16);
    chk("t2 X command", s_prev_cmd[0], 4'b0001);
    chk("t2 Y command", s_last_cmd[0], 4'b0010);
    chk("t2 X mosi rises 5-16", s_prev_tail[0], 0);
    chk("t2 Y mosi rises 5-16", s_last_tail[0], 0);

    // Periodic sampling with en held high
    sx[0] = 12'h800; sy[0] = 12'h7FF;
    np = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (valid_w[0]) begin
        np++;
        chk("t3 pulse spacing", last_v[0] - prev_v[0], SP_A);
        chk("t3 xvalue", xv_w[0], 12'h800);
        chk("t3 yvalue", yv_w[0], 12'h7FF);
      end
    end
    chk("t3 pulse count", np, 5);

    // Reset on the 7th sclk rise of the Y frame
    wait_off(0, 2 * CD + FRAME + GAP + 6 * 2 * CD, 400, "t4 reach Y rise 7");
    chk("t4 sclk rising", sclk_w[0], 1);
    rst = 1'b1;
    tick();
    chk("t4 cs_n after rst", cs_n_w[0], 1);
    chk("t4 sclk after rst", sclk_w[0], 1);
    chk("t4 xvalue after rst", xv_w[0], 0);
    chk("t4 yvalue after rst", yv_w[0], 0);
    chk("t4 valid after rst", valid_w[0], 0);
    rst = 1'b0;
    vbase = vcnt[0];
    wait_valid(0, vbase + 1, 400, "t4 pair after reset");
    chk("t4 xvalue", xv_w[0], 12'h800);
    chk("t4 yvalue", yv_w[0], 12'h7FF);

    // en dropped during the X shift: pair still finishes once, then idle
    sx[0] = 12'h5A5; sy[0] = 12'h0F0;
    wait_off(0, 20, 400, "t5 reach X shift");
    en_r[0] = 1'b0;
    vbase = vcnt[0];
    low_after = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (vcnt[0] > vbase && !valid_w[0] && !cs_n_w[0]) low_after++;
    end
    chk("t5 pulse count", vcnt[0] - vbase, 1);
    chk("t5 xvalue", xv_w[0], 12'h5A5);
    chk("t5 yvalue", yv_w[0], 12'h0F0);
    chk("t5 busy idle", busy_w[0], 0);
    chk("t5 cs_n idle", cs_n_w[0], 1);
    chk("t5 cs_n low cycles after pair", low_after, 0);

    // Period shorter than a pair: back-to-back pairs with one cs_n-high cycle
    en_r[1] = 1'b1;
    wait_valid(1, 1, 400, "t6 first pair");
    chk("t6 cs_n before done", prev_cs[1], 0);
    chk("t6 cs_n at done", cs_n_w[1], 1);
    tick();
    chk("t6 cs_n after done", cs_n_w[1], 0);
    wait_valid(1, 2, 400, "t6 second pair");
    chk("t6 pulse spacing", last_v[1] - prev_v[1], PAIR_LEN);
    chk("t6 xvalue", xv_w[1], 12'h321);
    chk("t6 yvalue", yv_w[1], 12'hCDE);
    en_r[1] = 1'b0;
    repeat (200) tick();
    chk("t6 busy idle", busy_w[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
